// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM program loader.
//   state_e       : frame-parser FSM states
//   BYTE_W/WORD_W : UART byte and ROM word widths
//   LEN_W         : width of the big-endian frame length field
//   DEF_SYNC_BYTE : default frame start byte
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/rom_program_loader_if.sv
// Byte-stream input and ROM write / status output bundle of the loader.
//   rx_valid, rx_data, rx_ready : UART byte handshake (byte taken on valid & ready)
//   wr_en, wr_addr, wr_data     : ROM write port (one-cycle strobe)
//   cpu_hold, done, error       : boot status
// slave = loader side, master = byte source / ROM / CPU side.
interface rom_program_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
);

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

endinterface

// File: rtl/loader_timeout.sv
// Inter-byte idle counter for the loader.
//   clk, reset : clock, async active-high reset
//   clr        : return count to zero (takes priority over en)
//   en         : count one idle cycle
//   expired_c  : count has reached TIMEOUT_CYCLES (combinational)
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Saturates at the limit so a stalled count cannot wrap back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_program_loader.sv
// Boot loader: frames a UART byte stream (sync, length, words, checksum) and
// writes the words into the instruction ROM, holding the CPU in reset until a
// complete image with a good checksum has been loaded.
//   clk, reset : clock, async active-high reset
//   bus        : rom_program_loader_if.slave (byte input, ROM write, status)
module rom_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 15,
  parameter int unsigned       DEPTH          = 32768,
  parameter logic [BYTE_W-1:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned       TIMEOUT_CYCLES = 1000000
) (
  input logic                 clk,
  input logic                 reset,
  rom_program_loader_if.slave bus
);

  state_e            state_q, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic [BYTE_W-1:0] hi_q, hi_n;
  logic [BYTE_W-1:0] chk_q, chk_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [WORD_W-1:0] data_q, data_n;

  logic rx_ready_q, wr_en_q, cpu_hold_q, done_q, error_q;
  logic accept_c, tmo_win_c, tmo_expired_c;

  assign accept_c  = bus.rx_valid & rx_ready_q;
  assign tmo_win_c = (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
                                      ST_DATA_LO, ST_CHECK});

  // Idle cycles are only counted inside a frame while a byte is awaited.
  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept_c | ~tmo_win_c),
    .en       (tmo_win_c & ~accept_c),
    .expired_c(tmo_expired_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_n = state_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    hi_n    = hi_q;
    chk_n   = chk_q;
    addr_n  = addr_q;
    data_n  = data_q;

    if (tmo_win_c && tmo_expired_c) begin
      state_n = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (accept_c && bus.rx_data == SYNC_BYTE) begin
            state_n = ST_LEN_HI;
            chk_n   = '0;
            cnt_n   = '0;
            addr_n  = '0;
          end
        end
        ST_LEN_HI: begin
          if (accept_c) begin
            len_n   = {bus.rx_data, len_q[BYTE_W-1:0]};
            state_n = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept_c) begin
            len_n = {len_q[LEN_W-1:BYTE_W], bus.rx_data};
            if (32'(len_n) > DEPTH)  state_n = ST_ERROR;
            else if (len_n == '0)    state_n = ST_CHECK;
            else                     state_n = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          if (accept_c) begin
            hi_n    = bus.rx_data;
            chk_n   = chk_q + bus.rx_data;
            state_n = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (accept_c) begin
            data_n  = {hi_q, bus.rx_data};
            chk_n   = chk_q + bus.rx_data;
            state_n = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The strobe cycle holds addr/data; they advance on the way out.
          addr_n  = addr_q + ADDR_W'(1);
          cnt_n   = cnt_q + LEN_W'(1);
          state_n = (cnt_n == len_q) ? ST_CHECK : ST_DATA_HI;
        end
        ST_CHECK: begin
          if (accept_c) begin
            state_n = (bus.rx_data == chk_q) ? ST_DONE : ST_ERROR;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      len_q      <= len_n;
      cnt_q      <= cnt_n;
      hi_q       <= hi_n;
      chk_q      <= chk_n;
      addr_q     <= addr_n;
      data_q     <= data_n;
      rx_ready_q <= (state_n != ST_WRITE);
      wr_en_q    <= (state_n == ST_WRITE);
      cpu_hold_q <= (state_n != ST_DONE);
      done_q     <= (state_n == ST_DONE);
      error_q    <= (state_n == ST_ERROR);
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_rom_program_loader.sv
// Self-checking bench for rom_program_loader: directed frames plus randomized
// images; expected ROM writes are queued by a frame-level model and checked by
// an independent write monitor.
module tb_rom_program_loader;
  import loader_pkg::*;

  localparam int unsigned ADDR_W = 15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rom_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_program_loader #(
    .ADDR_W        (ADDR_W),
    .DEPTH         (32768),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_wr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int unsigned a, input logic [15:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Scoreboard monitor: every ROM write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && bus.wr_en) begin
      wr_t w;
      n_wr++;
      check("rx_ready_low_in_write", 32'(bus.rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(w.addr));
        check("wr_data", 32'(bus.wr_data), 32'(w.data));
      end
    end
  end

  // Offers one byte; returns at the falling edge after it was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.rx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: rx_ready 0, expected 1 within 10 cycles");
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_all();
    while (frame_q.size() != 0) send_byte(frame_q.pop_front());
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_err);
    check({name, "_done"},     32'(bus.done),     32'(exp_done));
    check({name, "_error"},    32'(bus.error),    32'(exp_err));
    check({name, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
  endtask

  task automatic wait_error(input string name);
    int k = 0;
    while (!bus.error && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(bus.error), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_wr_en",    32'(bus.wr_en),    32'd0);
    check("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    check_status("rst", 1'b0, 1'b0);
    reset = 1'b0;

    // Good load of three words.
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h00, 8'h00, 8'hFF};
    push_exp(0, 16'h0003); push_exp(1, 16'hEC10); push_exp(2, 16'h0000);
    send_all();
    check_status("good", 1'b1, 1'b0);
    check("good_pending", 32'(exp_q.size()), 32'd0);

    // Reset asserted between clock edges takes effect immediately.
    #3 reset = 1'b1;
    #1;
    check("async_rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("async_rst_wr_en",    32'(bus.wr_en),    32'd0);
    check("async_rst_done",     32'(bus.done),     32'd0);
    check("async_rst_error",    32'(bus.error),    32'd0);
    check("async_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Bad checksum, then the good frame again.
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h00, 8'h00, 8'hFE};
    push_exp(0, 16'h0003); push_exp(1, 16'hEC10); push_exp(2, 16'h0000);
    send_all();
    check_status("badchk", 1'b0, 1'b1);
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h03, 8'hEC, 8'h10, 8'h00, 8'h00, 8'hFF};
    push_exp(0, 16'h0003); push_exp(1, 16'hEC10); push_exp(2, 16'h0000);
    send_all();
    check_status("reload", 1'b1, 1'b0);

    // Oversize length, then a zero-length image.
    wr0 = n_wr;
    frame_q = '{8'hA5, 8'h80, 8'h01};
    send_all();
    check_status("oversize", 1'b0, 1'b1);
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_all();
    check_status("zero_len", 1'b1, 1'b0);
    check("no_writes_len", 32'(n_wr - wr0), 32'd0);

    // Length exactly DEPTH is accepted: first word written, then starve it.
    frame_q = '{8'hA5, 8'h80, 8'h00, 8'h12, 8'h34};
    push_exp(0, 16'h1234);
    send_all();
    wait_error("depth_timeout_error");
    check("depth_pending", 32'(exp_q.size()), 32'd0);

    // Timeout mid-word: no write, error only after the idle limit.
    wr0 = n_wr;
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_all();
    repeat (10) @(negedge clk);
    check("early_error", 32'(bus.error), 32'd0);
    wait_error("timeout_error");
    frame_q = '{8'h00, 8'hFF};
    send_all();
    check_status("junk", 1'b0, 1'b1);
    check("no_writes_timeout", 32'(n_wr - wr0), 32'd0);

    // Randomized images from a frame-level model.
    for (int f = 0; f < 8; f++) begin
      int unsigned len;
      logic        bad;
      logic [7:0]  sum;
      logic [7:0]  j;
      logic [15:0] w;
      logic [15:0] lw;
      len = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      sum = 8'h00;
      frame_q.delete();
      if (f % 2 == 1) begin
        j = 8'($urandom());
        if (j == 8'hA5) j = 8'h5A;
        frame_q.push_back(j);
      end
      lw = 16'(len);
      frame_q.push_back(8'hA5);
      frame_q.push_back(lw[15:8]);
      frame_q.push_back(lw[7:0]);
      for (int i = 0; i < int'(len); i++) begin
        w = 16'($urandom());
        frame_q.push_back(w[15:8]);
        frame_q.push_back(w[7:0]);
        sum = sum + w[15:8] + w[7:0];
        push_exp(i, w);
      end
      frame_q.push_back(bad ? sum + 8'd1 : sum);
      send_all();
      check_status("rand", !bad, bad);
      check("rand_pending", 32'(exp_q.size()), 32'd0);
    end

    // Reset right after the first write aborts the load.
    frame_q = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h03};
    push_exp(0, 16'h0003);
    send_all();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr0 = n_wr;
    frame_q = '{8'hEC, 8'h10, 8'h00, 8'h00, 8'hFF};
    send_all();
    repeat (3) @(negedge clk);
    check_status("midrst", 1'b0, 1'b0);
    check("midrst_writes", 32'(n_wr - wr0), 32'd0);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
